// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Function : Round-robin grant sequencer for a shared 4:1 select datapath.
//            Holds a one-hot grant across multi-beat bursts until the last
//            beat is accepted. Optional macro ARB_TIMEOUT_EN adds beat-limit
//            preemption and the preempt output.
// Revision : 1.0  initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_WIDTH = 5,
    parameter int RESET_PTR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       bus_ready,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       bus_valid,
    output logic       bus_last,
    output logic [3:0] ack,
    output logic       busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic       preempt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max   = '1;
    localparam logic [1:0]           c_reset_ptr = 2'(RESET_PTR);

    if ((MAX_BEATS < 1) || (MAX_BEATS > (2 ** CNT_WIDTH) - 1)) begin : g_bad_max_beats
        $error("mux4_rr_arbiter: MAX_BEATS out of range for CNT_WIDTH");
    end
    if ((RESET_PTR < 0) || (RESET_PTR > 3)) begin : g_bad_reset_ptr
        $error("mux4_rr_arbiter: RESET_PTR must be 0..3");
    end

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_grant, w_grant_nxt;
    logic [1:0]            r_sel, w_sel_nxt;
    logic [1:0]            r_ptr, w_ptr_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [2:0]            w_pick_idle, w_pick_next;
    logic                  w_accept, w_done, w_abort, w_timeout, w_release;

    // Returns {found, index} of the first set bit at or after start, mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = start + 2'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    assign bus_valid = |(r_grant & req);
    assign bus_last  = |(r_grant & req & last);
    assign ack       = r_grant & req & {4{bus_ready}};
    assign grant     = r_grant;
    assign sel       = r_sel;
    assign busy      = (r_state == ST_BUSY);

    assign w_accept  = bus_valid & bus_ready;
    assign w_done    = w_accept & bus_last;
    assign w_abort   = ~bus_valid;
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

`ifdef ARB_TIMEOUT_EN
    assign w_timeout = w_accept & ~bus_last & (w_cnt_inc == CNT_WIDTH'(MAX_BEATS));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_release   = w_done | w_abort | w_timeout;
    assign w_pick_idle = rr_pick(req, r_ptr);
    // Holder is searched last so a lone re-requester is re-granted without a bubble.
    assign w_pick_next = rr_pick(req, r_sel + 2'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle[2]) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = 4'b0001 << w_pick_idle[1:0];
                    w_sel_nxt   = w_pick_idle[1:0];
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (w_release) begin
                    w_ptr_nxt = r_sel + 2'd1;
                    w_cnt_nxt = '0;
                    if (w_pick_next[2]) begin
                        w_grant_nxt = 4'b0001 << w_pick_next[1:0];
                        w_sel_nxt   = w_pick_next[1:0];
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 4'b0000;
                        w_sel_nxt   = 2'd0;
                    end
                end else if (w_accept) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= c_reset_ptr;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic r_preempt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= (r_state == ST_BUSY) & w_timeout;
        end
    end

    assign preempt = r_preempt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Function : Cycle-by-cycle vector bench for mux4_rr_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic       bus_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       bus_valid;
    logic       bus_last;
    logic [3:0] ack;
    logic       busy;
`ifdef ARB_TIMEOUT_EN
    logic       preempt;
`endif

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(
        .MAX_BEATS (4),
        .CNT_WIDTH (5),
        .RESET_PTR (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .bus_ready (bus_ready),
        .grant     (grant),
        .sel       (sel),
        .bus_valid (bus_valid),
        .bus_last  (bus_last),
        .ack       (ack),
        .busy      (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .preempt   (preempt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] grant;
        logic [1:0] sel;
        logic [3:0] ack;
        logic       valid;
        logic       blast;
        logic       busy;
        logic       pre;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst, logic [3:0] rq, logic [3:0] ls, logic rdy,
                               logic [3:0] gnt, logic [1:0] s, logic [3:0] ak,
                               logic vl, logic bl, logic bz, logic pe);
        vec_t r;
        r.rst = rst; r.req = rq; r.last = ls; r.rdy = rdy;
        r.grant = gnt; r.sel = s; r.ack = ak;
        r.valid = vl; r.blast = bl; r.busy = bz; r.pre = pe;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        int acks;
        int bad;

        // Each record: inputs for one cycle, outputs expected in that cycle.
        // A: single requester, single beat (back-to-back re-grant, then abort).
        vecs.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'h1, 4'h1, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'h1, 4'h1, 1, 4'h1, 2'd0, 4'h1, 1, 1, 1, 0));
        vecs.push_back(v(0, 4'h0, 4'h0, 1, 4'h1, 2'd0, 4'h0, 0, 0, 1, 0));
        vecs.push_back(v(0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        // B: all requesting single-beat transfers, no bubble.
        vecs.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'hF, 4'hF, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'hF, 4'hF, 1, 4'h1, 2'd0, 4'h1, 1, 1, 1, 0));
        vecs.push_back(v(0, 4'hF, 4'hF, 1, 4'h2, 2'd1, 4'h2, 1, 1, 1, 0));
        vecs.push_back(v(0, 4'hF, 4'hF, 1, 4'h4, 2'd2, 4'h4, 1, 1, 1, 0));
        vecs.push_back(v(0, 4'hF, 4'hF, 1, 4'h8, 2'd3, 4'h8, 1, 1, 1, 0));
        vecs.push_back(v(0, 4'hF, 4'hF, 1, 4'h1, 2'd0, 4'h1, 1, 1, 1, 0));
        vecs.push_back(v(0, 4'h0, 4'h0, 1, 4'h2, 2'd1, 4'h0, 0, 0, 1, 0));
        vecs.push_back(v(0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        // C: req[2] 4-beat burst, beat 2 stalled 3 cycles.
        vecs.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'h4, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'h4, 4'h0, 1, 4'h4, 2'd2, 4'h4, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h4, 4'h0, 0, 4'h4, 2'd2, 4'h0, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h4, 4'h0, 0, 4'h4, 2'd2, 4'h0, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h4, 4'h0, 0, 4'h4, 2'd2, 4'h0, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h4, 4'h0, 1, 4'h4, 2'd2, 4'h4, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h4, 4'h0, 1, 4'h4, 2'd2, 4'h4, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h4, 4'h4, 1, 4'h4, 2'd2, 4'h4, 1, 1, 1, 0));
        vecs.push_back(v(0, 4'h0, 4'h0, 1, 4'h4, 2'd2, 4'h0, 0, 0, 1, 0));
        vecs.push_back(v(0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        // D: new requests during req[1] grant; ptr=2 picks 3, then 0.
        vecs.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'h2, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'hB, 4'h0, 1, 4'h2, 2'd1, 4'h2, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'hB, 4'h2, 1, 4'h2, 2'd1, 4'h2, 1, 1, 1, 0));
        vecs.push_back(v(0, 4'h9, 4'h9, 1, 4'h8, 2'd3, 4'h8, 1, 1, 1, 0));
        vecs.push_back(v(0, 4'h1, 4'h1, 1, 4'h1, 2'd0, 4'h1, 1, 1, 1, 0));
        vecs.push_back(v(0, 4'h0, 4'h0, 1, 4'h1, 2'd0, 4'h0, 0, 0, 1, 0));
        vecs.push_back(v(0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        // E: abort leaves ptr=3; mid-burst reset clears grant and ptr.
        vecs.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'h4, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'h4, 4'h0, 1, 4'h4, 2'd2, 4'h4, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h0, 4'h0, 1, 4'h4, 2'd2, 4'h0, 0, 0, 1, 0));
        vecs.push_back(v(0, 4'hF, 4'h0, 0, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'hF, 4'h0, 0, 4'h8, 2'd3, 4'h0, 1, 0, 1, 0));
        vecs.push_back(v(1, 4'hF, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'hF, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'hF, 4'h0, 1, 4'h1, 2'd0, 4'h1, 1, 0, 1, 0));
        vecs.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
`ifdef ARB_TIMEOUT_EN
        // F: req[0] streams without last; 4th accept forces hand-over to 1.
        vecs.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'h3, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'h3, 4'h0, 1, 4'h1, 2'd0, 4'h1, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h3, 4'h0, 1, 4'h1, 2'd0, 4'h1, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h3, 4'h0, 1, 4'h1, 2'd0, 4'h1, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h3, 4'h0, 1, 4'h1, 2'd0, 4'h1, 1, 0, 1, 0));
        vecs.push_back(v(0, 4'h3, 4'h0, 1, 4'h2, 2'd1, 4'h2, 1, 0, 1, 1));
        vecs.push_back(v(0, 4'h3, 4'h0, 1, 4'h2, 2'd1, 4'h2, 1, 0, 1, 0));
        vecs.push_back(v(1, 4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0));
`endif

        rst_n = 1'b0; req = 4'h0; last = 4'h0; bus_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n     = ~vecs[i].rst;
            req       = vecs[i].req;
            last      = vecs[i].last;
            bus_ready = vecs[i].rdy;
            #1;
            chk("grant",     i, 32'(grant),     32'(vecs[i].grant));
            chk("sel",       i, 32'(sel),       32'(vecs[i].sel));
            chk("ack",       i, 32'(ack),       32'(vecs[i].ack));
            chk("bus_valid", i, 32'(bus_valid), 32'(vecs[i].valid));
            chk("bus_last",  i, 32'(bus_last),  32'(vecs[i].blast));
            chk("busy",      i, 32'(busy),      32'(vecs[i].busy));
`ifdef ARB_TIMEOUT_EN
            chk("preempt",   i, 32'(preempt),   32'(vecs[i].pre));
`endif
            @(posedge clk);
            #1;
        end

        // Burst on req[2] with an irregular ready pattern: grant must hold
        // and exactly four acks must be seen before release.
        rst_n = 1'b0; req = 4'h0; last = 4'h0; bus_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; req = 4'h4;
        @(posedge clk); #1;
        acks = 0;
        bad  = 0;
        for (int c = 0; c < 40 && acks < 4; c++) begin
            bus_ready = ((c % 3) != 1);
            last      = (acks == 3) ? 4'h4 : 4'h0;
            #1;
            if (grant !== 4'h4 || sel !== 2'd2) bad++;
            if (ack[2] === 1'b1) acks++;
            @(posedge clk); #1;
        end
        chk("burst_acks", 1000, 32'(acks), 32'd4);
        chk("burst_hold", 1000, 32'(bad), 32'd0);
        req = 4'h0; last = 4'h0;
        for (int c = 0; c < 4 && busy === 1'b1; c++) begin
            @(posedge clk); #1;
        end
        chk("burst_release", 1000, 32'(busy), 32'd0);
        chk("burst_grant_clear", 1000, 32'(grant), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
